// File: rtl/note_sequencer.sv
// Note sequencer: plays a programmed table of {frequency, waveform, duration}
// entries by driving the tone generator's frequency and waveform-select inputs.
module note_sequencer #(
    parameter int depth_p     = 16,
    parameter int clk_freq_p  = 12_000_000,
    parameter int tick_hz_p   = 1000,
    parameter int dur_width_p = 16,
    parameter int gap_ticks_p = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       wr_v_i,
    input  logic [$clog2(depth_p)-1:0] wr_addr_i,
    input  logic [15:0]                wr_freq_i,
    input  logic [3:0]                 wr_wave_i,
    input  logic [dur_width_p-1:0]     wr_dur_i,
    output logic                       wr_ready_o,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       loop_i,
    input  logic [$clog2(depth_p):0]   len_i,
    output logic [15:0]                freq_o,
    output logic [3:0]                 sw_o,
    output logic                       gate_o,
    output logic                       busy_o,
    output logic [$clog2(depth_p)-1:0] note_idx_o,
    output logic                       done_o
);

    localparam int idx_w        = $clog2(depth_p);
    localparam int len_w        = idx_w + 1;
    localparam int cyc_per_tick = clk_freq_p / tick_hz_p;
    localparam int presc_w      = (cyc_per_tick > 1) ? $clog2(cyc_per_tick) : 1;
    localparam int gap_w        = $clog2(gap_ticks_p + 1);
    localparam int cnt_w        = (dur_width_p > gap_w) ? dur_width_p : gap_w;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    state_t               state_q, state_d;
    logic [idx_w-1:0]     idx_q, idx_d;
    logic [len_w-1:0]     len_q, len_d;
    logic                 loop_q, loop_d;
    logic [cnt_w-1:0]     cnt_q, cnt_d;
    logic [presc_w-1:0]   presc_q, presc_d;
    logic [15:0]          freq_q, freq_d;
    logic [3:0]           sw_q, sw_d;
    logic                 gate_q, gate_d;
    logic [idx_w-1:0]     nidx_q, nidx_d;
    logic                 done_q, done_d;

    logic [15:0]            freq_mem [depth_p];
    logic [3:0]             wave_mem [depth_p];
    logic [dur_width_p-1:0] dur_mem  [depth_p];

    logic [15:0]            fetch_freq;
    logic [3:0]             fetch_wave;
    logic [dur_width_p-1:0] fetch_dur;
    logic                   tick;
    logic                   advance;
    logic                   to_idle;

    // NOTE: the note table deliberately has no reset; it holds no control
    // state, so it can map onto plain storage without a reset net.
    always_ff @(posedge clk_i) begin
        if (wr_v_i && state_q == IDLE) begin
            freq_mem[wr_addr_i] <= wr_freq_i;
            wave_mem[wr_addr_i] <= wr_wave_i;
            dur_mem[wr_addr_i]  <= wr_dur_i;
        end
    end

    assign fetch_freq = freq_mem[idx_q];
    assign fetch_wave = wave_mem[idx_q];
    assign fetch_dur  = dur_mem[idx_q];

    // The prescaler only runs while timing a note or gap, so every tick lands
    // a whole number of tick periods after the state was entered.
    assign tick = (state_q == PLAY || state_q == GAP) &&
                  (presc_q == presc_w'(cyc_per_tick - 1));

    // NOTE: every variable gets a default before the case statement so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        presc_d = '0;
        freq_d  = freq_q;
        sw_d    = sw_q;
        gate_d  = gate_q;
        nidx_d  = nidx_q;
        done_d  = 1'b0;
        advance = 1'b0;
        to_idle = 1'b0;

        if (state_q == PLAY || state_q == GAP) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    loop_d = loop_i;
                    idx_d  = '0;
                    len_d  = (len_i > len_w'(depth_p)) ? len_w'(depth_p) : len_i;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (fetch_dur == '0) begin
                    advance = 1'b1;
                end else begin
                    state_d = PLAY;
                    cnt_d   = cnt_w'(fetch_dur);
                    freq_d  = fetch_freq;
                    nidx_d  = idx_q;
                    gate_d  = (fetch_freq != '0);
                    sw_d    = (fetch_freq != '0) ? fetch_wave : 4'b0000;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (cnt_q == cnt_w'(1)) begin
                        if (gap_ticks_p > 0) begin
                            state_d = GAP;
                            cnt_d   = cnt_w'(gap_ticks_p);
                            sw_d    = 4'b0000;
                            gate_d  = 1'b0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_q == cnt_w'(1)) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if ((len_w'(idx_q) + len_w'(1)) < len_q) begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = FETCH;
            end else begin
                to_idle = 1'b1;
                done_d  = 1'b1;
            end
        end

        // Abort outranks both a pending expiry and a natural end of sequence.
        if (stop_i && state_q != IDLE) begin
            to_idle = 1'b1;
            done_d  = 1'b0;
        end

        if (to_idle) begin
            state_d = IDLE;
            idx_d   = '0;
            freq_d  = '0;
            sw_d    = 4'b0000;
            gate_d  = 1'b0;
            nidx_d  = '0;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            cnt_q   <= '0;
            presc_q <= '0;
            freq_q  <= '0;
            sw_q    <= 4'b0000;
            gate_q  <= 1'b0;
            nidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            freq_q  <= freq_d;
            sw_q    <= sw_d;
            gate_q  <= gate_d;
            nidx_q  <= nidx_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign wr_ready_o = (state_q == IDLE);
    assign freq_o     = freq_q;
    assign sw_o       = sw_q;
    assign gate_o     = gate_q;
    assign note_idx_o = nidx_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a timeline model expands the note table into the
// per-cycle outputs expected after each start and a compare process checks them.
module tb_note_sequencer;

    localparam int DEPTH = 4;
    localparam int CPT   = 10;
    localparam int GAP   = 1;

    typedef struct packed {
        logic        busy;
        logic        rdy;
        logic [15:0] freq;
        logic [3:0]  sw;
        logic        gate;
        logic [1:0]  idx;
        logic        done;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        wr_v_i;
    logic [1:0]  wr_addr_i;
    logic [15:0] wr_freq_i;
    logic [3:0]  wr_wave_i;
    logic [7:0]  wr_dur_i;
    logic        wr_ready_o;
    logic        start_i;
    logic        stop_i;
    logic        loop_i;
    logic [2:0]  len_i;
    logic [15:0] freq_o;
    logic [3:0]  sw_o;
    logic        gate_o;
    logic        busy_o;
    logic [1:0]  note_idx_o;
    logic        done_o;

    note_sequencer #(
        .depth_p    (DEPTH),
        .clk_freq_p (1000),
        .tick_hz_p  (100),
        .dur_width_p(8),
        .gap_ticks_p(GAP)
    ) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_v_i    (wr_v_i),
        .wr_addr_i (wr_addr_i),
        .wr_freq_i (wr_freq_i),
        .wr_wave_i (wr_wave_i),
        .wr_dur_i  (wr_dur_i),
        .wr_ready_o(wr_ready_o),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .loop_i    (loop_i),
        .len_i     (len_i),
        .freq_o    (freq_o),
        .sw_o      (sw_o),
        .gate_o    (gate_o),
        .busy_o    (busy_o),
        .note_idx_o(note_idx_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    exp_t exp_q[$];
    logic [15:0] sh_freq [DEPTH];
    logic [3:0]  sh_wave [DEPTH];
    logic [7:0]  sh_dur  [DEPTH];

    int   done_cnt, busy_cyc, gate_cyc;
    logic gate_prev = 1'b0;
    logic [1:0] rise_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r     = '0;
        r.rdy = 1'b1;
        return r;
    endfunction

    function automatic exp_t dut_outs();
        exp_t r;
        r.busy = busy_o;
        r.rdy  = wr_ready_o;
        r.freq = freq_o;
        r.sw   = sw_o;
        r.gate = gate_o;
        r.idx  = note_idx_o;
        r.done = done_o;
        return r;
    endfunction

    // Per-cycle comparison against the model timeline.
    always @(negedge clk_i) begin
        exp_t e;
        if (reset_ni && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", 64'(dut_outs()), 64'(e));
        end
    end

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            gate_prev = 1'b0;
        end else begin
            if (done_o) done_cnt++;
            if (busy_o) busy_cyc++;
            if (gate_o) gate_cyc++;
            if (gate_o && !gate_prev) rise_q.push_back(note_idx_o);
            gate_prev = gate_o;
        end
    end

    task automatic clr();
        done_cnt = 0;
        busy_cyc = 0;
        gate_cyc = 0;
        rise_q.delete();
    endtask

    function automatic void push(input exp_t e, input int cap);
        if (exp_q.size() < cap) exp_q.push_back(e);
    endfunction

    // Expands the shadow table into the outputs seen in each cycle after the
    // start edge: one fetch cycle per entry, dur*CPT sounding cycles, GAP*CPT muted.
    task automatic gen(input int len, input bit lp, input int stop_at);
        exp_t cur, e;
        int   cap, n, i;
        bit   fin;
        cap = (stop_at >= 0) ? stop_at + 1 : 1_000_000;
        n   = (len > DEPTH) ? DEPTH : len;
        if (n == 0) begin
            e      = idle_rec();
            e.done = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(idle_rec());
            return;
        end
        cur      = '0;
        cur.busy = 1'b1;
        i        = 0;
        fin      = 1'b0;
        while (!fin && exp_q.size() < cap) begin
            push(cur, cap);
            if (sh_dur[i] != 0) begin
                cur.freq = sh_freq[i];
                cur.idx  = 2'(i);
                cur.gate = (sh_freq[i] != 0);
                cur.sw   = cur.gate ? sh_wave[i] : 4'b0000;
                for (int k = 0; k < int'(sh_dur[i]) * CPT; k++) push(cur, cap);
                if (GAP > 0) begin
                    cur.sw   = 4'b0000;
                    cur.gate = 1'b0;
                    for (int k = 0; k < GAP * CPT; k++) push(cur, cap);
                end
            end
            if (i + 1 < n) i++;
            else if (lp) i = 0;
            else begin
                e      = idle_rec();
                e.done = 1'b1;
                push(e, cap);
                push(idle_rec(), cap);
                fin = 1'b1;
            end
        end
        if (stop_at >= 0 && exp_q.size() >= cap) begin
            exp_q.push_back(idle_rec());
            exp_q.push_back(idle_rec());
        end
    endtask

    task automatic wr(input int a, input logic [15:0] f, input logic [3:0] w, input logic [7:0] d);
        wr_v_i    = 1'b1;
        wr_addr_i = 2'(a);
        wr_freq_i = f;
        wr_wave_i = w;
        wr_dur_i  = d;
        @(posedge clk_i); #1;
        wr_v_i     = 1'b0;
        sh_freq[a] = f;
        sh_wave[a] = w;
        sh_dur[a]  = d;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk_i); #1;
            c++;
            if (c > 3000) begin
                check("drain_budget", 64'(c), 64'(3000));
                exp_q.delete();
            end
        end
    endtask

    // Starts playback and applies side stimulus at given cycle offsets
    // (cycle 0 is the first cycle after the start edge; -1 disables).
    task automatic run(input int len, input bit lp, input int stop_at,
                       input int wr_at, input int start_at, input int abort_at);
        int c;
        start_i = 1'b1;
        len_i   = 3'(len);
        loop_i  = lp;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        len_i   = '0;
        loop_i  = 1'b0;
        gen(len, lp, stop_at);
        c = 0;
        while (exp_q.size() > 0) begin
            if (c == abort_at) begin
                #2;
                reset_ni = 1'b0;
                exp_q.delete();
                break;
            end
            if (c == stop_at) stop_i = 1'b1;
            if (c == wr_at) begin
                wr_v_i    = 1'b1;
                wr_addr_i = 2'd0;
                wr_freq_i = 16'd1234;
                wr_wave_i = 4'b1000;
                wr_dur_i  = 8'd5;
            end
            if (c == start_at) begin
                start_i = 1'b1;
                len_i   = 3'd1;
            end
            @(posedge clk_i); #1;
            stop_i  = 1'b0;
            wr_v_i  = 1'b0;
            start_i = 1'b0;
            c++;
            if (c > 3000) begin
                check("run_budget", 64'(c), 64'(3000));
                exp_q.delete();
            end
        end
    endtask

    initial begin
        logic [9:0] seq;
        reset_ni  = 1'b0;
        wr_v_i    = 1'b0;
        wr_addr_i = '0;
        wr_freq_i = '0;
        wr_wave_i = '0;
        wr_dur_i  = '0;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        loop_i    = 1'b0;
        len_i     = '0;
        #23;
        check("reset_outputs", 64'(dut_outs()), 64'(idle_rec()));
        #4 reset_ni = 1'b1;
        @(posedge clk_i); #1;

        // Two notes with a gap after each.
        wr(0, 16'd440, 4'b0001, 8'd3);
        wr(1, 16'd880, 4'b0010, 8'd2);
        clr();
        run(2, 1'b0, -1, -1, -1, -1);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
        check("t1_gate_cycles", 64'(gate_cyc), 64'd50);
        check("t1_busy_cycles", 64'(busy_cyc), 64'd72);

        // Rest entry between two notes.
        wr(0, 16'd440, 4'b0001, 8'd1);
        wr(1, 16'd0,   4'b0100, 8'd2);
        wr(2, 16'd880, 4'b0010, 8'd1);
        clr();
        run(3, 1'b0, -1, -1, -1, -1);
        check("t2_gate_cycles", 64'(gate_cyc), 64'd20);
        check("t2_done_pulses", 64'(done_cnt), 64'd1);

        // Zero-duration middle entry is skipped.
        wr(1, 16'd300, 4'b1000, 8'd0);
        clr();
        run(3, 1'b0, -1, -1, -1, -1);
        check("t3_note_count", 64'(rise_q.size()), 64'd2);
        check("t3_idx_jump", 64'({rise_q[0], rise_q[1]}), 64'({2'd0, 2'd2}));

        // Looping, ignored write and start while busy, then stop.
        wr(1, 16'd880, 4'b0010, 8'd1);
        clr();
        run(2, 1'b1, 100, 30, 50, -1);
        seq = '0;
        foreach (rise_q[k]) seq = {seq[7:0], rise_q[k]};
        check("t4_done_never", 64'(done_cnt), 64'd0);
        check("t4_note_count", 64'(rise_q.size()), 64'd5);
        check("t4_idx_seq", 64'(seq), 64'h044);
        check("t4_stopped_idle", 64'(dut_outs()), 64'(idle_rec()));

        // Replay: entry 0 must be unchanged by the write issued during playback.
        clr();
        run(2, 1'b0, -1, -1, -1, -1);
        check("t5_done_pulses", 64'(done_cnt), 64'd1);

        // Simultaneous start and stop in IDLE.
        clr();
        start_i = 1'b1;
        stop_i  = 1'b1;
        len_i   = 3'd2;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        len_i   = '0;
        repeat (3) exp_q.push_back(idle_rec());
        drain();
        check("t6_never_busy", 64'(busy_cyc), 64'd0);

        // Zero length.
        clr();
        run(0, 1'b0, -1, -1, -1, -1);
        check("t7_done_pulses", 64'(done_cnt), 64'd1);
        check("t7_never_busy", 64'(busy_cyc), 64'd0);

        // Length above depth is clamped.
        wr(2, 16'd300, 4'b0100, 8'd1);
        wr(3, 16'd400, 4'b1000, 8'd1);
        clr();
        run(7, 1'b0, -1, -1, -1, -1);
        check("t8_note_count", 64'(rise_q.size()), 64'd4);

        // Looping over all-zero durations, then stop.
        wr(0, 16'd440, 4'b0001, 8'd0);
        wr(1, 16'd880, 4'b0010, 8'd0);
        clr();
        run(2, 1'b1, 20, -1, -1, -1);
        check("t9_gate_cycles", 64'(gate_cyc), 64'd0);
        check("t9_done_never", 64'(done_cnt), 64'd0);

        // Asynchronous reset mid-note, then the table still plays.
        wr(0, 16'd440, 4'b0001, 8'd3);
        wr(1, 16'd880, 4'b0010, 8'd2);
        clr();
        run(2, 1'b0, -1, -1, -1, 15);
        #1;
        check("async_reset_outputs", 64'(dut_outs()), 64'(idle_rec()));
        @(negedge clk_i); #2;
        reset_ni = 1'b1;
        @(posedge clk_i); #1;
        clr();
        run(2, 1'b0, -1, -1, -1, -1);
        check("t10_done_pulses", 64'(done_cnt), 64'd1);
        check("t10_gate_cycles", 64'(gate_cyc), 64'd50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
